// File: rtl/note_recorder.sv
// note_recorder -- records a stream of played notes into an external memory.
//
// Each grabar rising edge starts a new take. While grabar stays high, every
// tick_muestra samples the current octave/note, encodes it as a single code
// (1..65, or 0 for silence/invalid), and writes it to the next address in a
// one-cycle WRITE state. The take stops at the last address (FULL) unless the
// circular option is built in.
//
// Build option:
//   NOTE_RECORDER_WRAP_EN  defined -> pointer wraps to 0, FULL is never entered,
//                          largo saturates at 2**ADDR_W.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   grabar        record request level (rising edge starts a take)
//   tick_muestra  one-cycle sample strobe
//   nro_octava    octave 1..5
//   nota_entrada  note 1..13, 0 = silence
//   mem_we        write enable, high only in WRITE
//   mem_addr      write address (held outside WRITE)
//   mem_wdata     encoded note code (held outside WRITE)
//   grabando      high in REC, WRITE and FULL
//   lleno         high in FULL
//   largo         valid entries in the current take, held until next take
module note_recorder #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              grabar,
   input  logic              tick_muestra,
   input  logic [2:0]        nro_octava,
   input  logic [3:0]        nota_entrada,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              grabando,
   output logic              lleno,
   output logic [ADDR_W:0]   largo
);

   typedef enum logic [1:0] {IDLE, REC, WRITE, FULL} state_t;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
`ifndef NOTE_RECORDER_WRAP_EN
   localparam logic [ADDR_W-1:0] LAST = '1;
`endif

   state_t            state, state_d;
   logic [ADDR_W-1:0] ptr;
   logic              grabar_q;
   logic              rst_q;
   logic              rise;
   logic [7:0]        code;
   logic              start_take, latch_en, wr_done;

   // rst_q masks the first cycle after reset so a grabar level held high
   // through reset does not look like a rising edge.
   assign rise = grabar & ~grabar_q & ~rst_q;

   always_comb begin
      code = 8'd0;
      if (nro_octava >= 3'd1 && nro_octava <= 3'd5 &&
          nota_entrada >= 4'd1 && nota_entrada <= 4'd13)
         code = 8'd13 * ({5'd0, nro_octava} - 8'd1) + {4'd0, nota_entrada};
   end

   always_comb begin
      state_d    = state;
      start_take = 1'b0;
      latch_en   = 1'b0;
      wr_done    = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_d    = REC;
               start_take = 1'b1;
            end
         end
         REC: begin
            // dropping grabar wins over a same-cycle tick
            if (!grabar)
               state_d = IDLE;
            else if (tick_muestra) begin
               state_d  = WRITE;
               latch_en = 1'b1;
            end
         end
         WRITE: begin
            wr_done = 1'b1;
`ifdef NOTE_RECORDER_WRAP_EN
            state_d = grabar ? REC : IDLE;
`else
            if (ptr == LAST)
               state_d = FULL;
            else
               state_d = grabar ? REC : IDLE;
`endif
         end
         FULL: begin
            if (!grabar)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         mem_addr  <= '0;
         mem_wdata <= 8'd0;
         largo     <= '0;
         grabar_q  <= 1'b0;
         rst_q     <= 1'b1;
      end else begin
         state    <= state_d;
         grabar_q <= grabar;
         rst_q    <= 1'b0;
         if (start_take) begin
            ptr   <= '0;
            largo <= '0;
         end
         // address and code registers only move on entry to WRITE, so they
         // stay stable in every other state
         if (latch_en) begin
            mem_addr  <= ptr;
            mem_wdata <= code;
         end
         if (wr_done) begin
            ptr <= ptr + ADDR_W'(1);
            if (largo != DEPTH)
               largo <= largo + (ADDR_W+1)'(1);
         end
      end
   end

   assign mem_we   = (state == WRITE);
   assign grabando = (state != IDLE);
   assign lleno    = (state == FULL);

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder. Two instances share stimulus: ADDR_W=8
// for the functional scenarios and ADDR_W=3 for the full / wrap scenario.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_note_recorder;

   logic       clk, rst, grabar, tick;
   logic [2:0] oct;
   logic [3:0] nota;

   logic       we8, grab8, lleno8;
   logic [7:0] addr8, wd8;
   logic [8:0] largo8;
   logic       we3, grab3, lleno3;
   logic [2:0] addr3;
   logic [7:0] wd3;
   logic [3:0] largo3;

   int tests = 0;
   int fails = 0;

   note_recorder u_dut8 (
      .clk(clk), .rst(rst), .grabar(grabar), .tick_muestra(tick),
      .nro_octava(oct), .nota_entrada(nota),
      .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8),
      .grabando(grab8), .lleno(lleno8), .largo(largo8)
   );

   note_recorder #(.ADDR_W(3)) u_dut3 (
      .clk(clk), .rst(rst), .grabar(grabar), .tick_muestra(tick),
      .nro_octava(oct), .nota_entrada(nota),
      .mem_we(we3), .mem_addr(addr3), .mem_wdata(wd3),
      .grabando(grab3), .lleno(lleno3), .largo(largo3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; grabar = 1'b0; tick = 1'b0; oct = 3'd1; nota = 4'd0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
   endtask

   // leaves both instances in REC
   task automatic start_take();
      grabar = 1'b0; cyc();
      grabar = 1'b1; cyc();
   endtask

   // one strobe; returns in the WRITE cycle
   task automatic do_tick(input logic [2:0] o, input logic [3:0] n);
      oct = o; nota = n; tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; grabar = 1'b0; tick = 1'b0; oct = 3'd1; nota = 4'd0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      tests++; if (we8 !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", we8); end
      tests++; if (addr8 !== 8'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", addr8); end
      tests++; if (wd8 !== 8'd0) begin fails++; $display("FAIL reset_wdata got %0d want 0", wd8); end
      tests++; if (grab8 !== 1'b0) begin fails++; $display("FAIL reset_grabando got %b want 0", grab8); end
      tests++; if (lleno8 !== 1'b0 || lleno3 !== 1'b0) begin fails++; $display("FAIL reset_lleno got %b/%b want 0", lleno8, lleno3); end
      tests++; if (largo8 !== 9'd0) begin fails++; $display("FAIL reset_largo got %0d want 0", largo8); end
   endtask

   task automatic test_hold_through_reset();
      grabar = 1'b1; rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      cyc(); cyc(); cyc();
      tests++; if (grab8 !== 1'b0) begin fails++; $display("FAIL hold_no_take got %b want 0", grab8); end
      grabar = 1'b0; cyc();
      grabar = 1'b1; cyc();
      tests++; if (grab8 !== 1'b1) begin fails++; $display("FAIL hold_new_rise got %b want 1", grab8); end
   endtask

   task automatic test_basic();
      do_reset();
      start_take();
      tests++; if (grab8 !== 1'b1) begin fails++; $display("FAIL basic_rec got %b want 1", grab8); end
      do_tick(3'd3, 4'd5);
      tests++; if (we8 !== 1'b1) begin fails++; $display("FAIL basic_we got %b want 1", we8); end
      tests++; if (addr8 !== 8'd0) begin fails++; $display("FAIL basic_addr got %0d want 0", addr8); end
      tests++; if (wd8 !== 8'd31) begin fails++; $display("FAIL basic_wdata got %0d want 31", wd8); end
      cyc();
      tests++; if (we8 !== 1'b0) begin fails++; $display("FAIL basic_we_drop got %b want 0", we8); end
      tests++; if (largo8 !== 9'd1) begin fails++; $display("FAIL basic_largo got %0d want 1", largo8); end
      tests++; if (addr8 !== 8'd0 || wd8 !== 8'd31) begin fails++; $display("FAIL basic_hold got %0d/%0d want 0/31", addr8, wd8); end
   endtask

   task automatic test_codes();
      logic [2:0] ov [4] = '{3'd5, 3'd1, 3'd6, 3'd2};
      logic [3:0] nv [4] = '{4'd13, 4'd1, 4'd2, 4'd0};
      logic [7:0] ev [4] = '{8'd65, 8'd1, 8'd0, 8'd0};
      do_reset();
      start_take();
      for (int i = 0; i < 4; i++) begin
         do_tick(ov[i], nv[i]);
         tests++; if (we8 !== 1'b1) begin fails++; $display("FAIL codes_we[%0d] got %b want 1", i, we8); end
         tests++; if (addr8 !== 8'(i)) begin fails++; $display("FAIL codes_addr[%0d] got %0d want %0d", i, addr8, i); end
         tests++; if (wd8 !== ev[i]) begin fails++; $display("FAIL codes_wdata[%0d] got %0d want %0d", i, wd8, ev[i]); end
         cyc();
      end
      tests++; if (largo8 !== 9'd4) begin fails++; $display("FAIL codes_largo got %0d want 4", largo8); end
   endtask

   task automatic test_full();
      logic [2:0] ea;
      int n;
      logic wrap;
`ifdef NOTE_RECORDER_WRAP_EN
      wrap = 1'b1; n = 10;
`else
      wrap = 1'b0; n = 9;
`endif
      do_reset();
      start_take();
      for (int i = 0; i < n; i++) begin
         ea = 3'(i % 8);
         do_tick(3'd1, 4'(i + 1));
         if (i < 8 || wrap) begin
            tests++; if (we3 !== 1'b1) begin fails++; $display("FAIL full_we[%0d] got %b want 1", i, we3); end
            tests++; if (addr3 !== ea) begin fails++; $display("FAIL full_addr[%0d] got %0d want %0d", i, addr3, ea); end
            tests++; if (wd3 !== 8'(i + 1)) begin fails++; $display("FAIL full_wdata[%0d] got %0d want %0d", i, wd3, i + 1); end
         end else begin
            tests++; if (we3 !== 1'b0) begin fails++; $display("FAIL full_extra_we got %b want 0", we3); end
         end
         cyc();
      end
      tests++; if (lleno3 !== !wrap) begin fails++; $display("FAIL full_lleno got %b want %b", lleno3, !wrap); end
      tests++; if (largo3 !== 4'd8) begin fails++; $display("FAIL full_largo got %0d want 8", largo3); end
      tests++; if (grab3 !== 1'b1) begin fails++; $display("FAIL full_grabando got %b want 1", grab3); end
      grabar = 1'b0; cyc();
      tests++; if (grab3 !== 1'b0 || lleno3 !== 1'b0) begin fails++; $display("FAIL full_exit got %b/%b want 0/0", grab3, lleno3); end
      tests++; if (largo3 !== 4'd8) begin fails++; $display("FAIL full_largo_held got %0d want 8", largo3); end
   endtask

   task automatic test_fall_tick();
      do_reset();
      start_take();
      do_tick(3'd2, 4'd3);
      cyc();
      grabar = 1'b0; tick = 1'b1;
      cyc();
      tick = 1'b0;
      tests++; if (we8 !== 1'b0) begin fails++; $display("FAIL fall_no_write got %b want 0", we8); end
      tests++; if (grab8 !== 1'b0) begin fails++; $display("FAIL fall_idle got %b want 0", grab8); end
      cyc();
      tests++; if (largo8 !== 9'd1) begin fails++; $display("FAIL fall_largo_held got %0d want 1", largo8); end
      grabar = 1'b1; cyc();
      tests++; if (grab8 !== 1'b1 || largo8 !== 9'd0) begin fails++; $display("FAIL fall_restart got %b/%0d want 1/0", grab8, largo8); end
      do_tick(3'd4, 4'd4);
      tests++; if (we8 !== 1'b1 || addr8 !== 8'd0 || wd8 !== 8'd43) begin fails++; $display("FAIL fall_rewrite got %b/%0d/%0d want 1/0/43", we8, addr8, wd8); end
      cyc();
      tests++; if (largo8 !== 9'd1) begin fails++; $display("FAIL fall_largo_new got %0d want 1", largo8); end
   endtask

   task automatic test_write_fall();
      do_reset();
      start_take();
      do_tick(3'd1, 4'd7);
      grabar = 1'b0;
      tests++; if (we8 !== 1'b1) begin fails++; $display("FAIL wfall_we got %b want 1", we8); end
      cyc();
      tests++; if (grab8 !== 1'b0 || largo8 !== 9'd1) begin fails++; $display("FAIL wfall_done got %b/%0d want 0/1", grab8, largo8); end
   endtask

   task automatic test_rst_write();
      do_reset();
      start_take();
      do_tick(3'd5, 4'd5);
      tests++; if (we8 !== 1'b1 || wd8 !== 8'd57) begin fails++; $display("FAIL rstw_pre got %b/%0d want 1/57", we8, wd8); end
      rst = 1'b1;
      cyc();
      tests++; if (we8 !== 1'b0) begin fails++; $display("FAIL rstw_we got %b want 0", we8); end
      tests++; if (addr8 !== 8'd0 || wd8 !== 8'd0 || largo8 !== 9'd0) begin fails++; $display("FAIL rstw_data got %0d/%0d/%0d want 0/0/0", addr8, wd8, largo8); end
      tests++; if (grab8 !== 1'b0 || lleno8 !== 1'b0) begin fails++; $display("FAIL rstw_state got %b/%b want 0/0", grab8, lleno8); end
      rst = 1'b0;
      cyc(); cyc();
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
      tests++; if (we8 !== 1'b0 || grab8 !== 1'b0) begin fails++; $display("FAIL rstw_no_retry got %b/%b want 0/0", we8, grab8); end
   endtask

   initial begin
      test_reset();
      test_hold_through_reset();
      test_basic();
      test_codes();
      test_full();
      test_fall_tick();
      test_write_fall();
      test_rst_write();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/note_recorder.md
NOTE_RECORDER -- requirements
Module: note_recorder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the recording memory address width; depth is 2**ADDR_W entries.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port grabar, input, 1, record request level; a rising edge starts a new take.
REQ-005 SHALL have port tick_muestra, input, 1, one-cycle sample strobe; consecutive strobes are at least 2 cycles apart.
REQ-006 SHALL have port nro_octava, input, 3, current octave, valid range 1..5.
REQ-007 SHALL have port nota_entrada, input, 4, current note: 1..13, or 0 for silence.
REQ-008 SHALL have port mem_we, output, 1, memory write enable.
REQ-009 SHALL have port mem_addr, output, ADDR_W, memory write address.
REQ-010 SHALL have port mem_wdata, output, 8, encoded note code written to memory.
REQ-011 SHALL have port grabando, output, 1, high in REC, WRITE and FULL.
REQ-012 SHALL have port lleno, output, 1, high in FULL.
REQ-013 SHALL have port largo, output, ADDR_W+1, number of valid entries in the current take.

Function
REQ-014 SHALL encode the note as code = 13*(nro_octava-1) + nota_entrada when nro_octava is in 1..5 and nota_entrada is in 1..13, giving codes 1..65.
REQ-015 SHALL encode every other input combination as code 0 (silence).
REQ-016 SHALL implement a four-state FSM: IDLE, REC, WRITE, FULL.
REQ-017 SHALL register the previous value of grabar for edge detection; a grabar rising edge is previous 0 and current 1.
REQ-018 SHALL, in IDLE on a grabar rising edge, clear the write pointer and largo to 0 and enter REC.
REQ-019 SHALL, in REC with grabar=0, enter IDLE; this takes priority over a simultaneous tick_muestra, so no write occurs.
REQ-020 SHALL, in REC with grabar=1 and tick_muestra=1, latch the code from the same-cycle inputs and enter WRITE.
REQ-021 SHALL, in WRITE, assert mem_we for exactly that one cycle, with mem_addr equal to the pointer and mem_wdata equal to the latched code; a tick then is ignored.
REQ-022 SHALL, on leaving WRITE, increment the pointer and increment largo, with largo saturating at 2**ADDR_W.
REQ-023 SHALL, when WRITE used the last address (2**ADDR_W-1), enter FULL; otherwise enter REC, or IDLE if grabar=0 in WRITE (the write still completes).
REQ-024 SHALL, in FULL, ignore tick_muestra and enter IDLE when grabar=0.
REQ-025 SHALL hold mem_we=0 in every state except WRITE.
REQ-026 SHALL hold mem_addr and mem_wdata stable outside WRITE.
REQ-027 SHALL hold largo until the next take starts, so it is readable in IDLE.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force state IDLE, the pointer, the latched code, and the previous-grabar register to 0.
REQ-029 SHALL, on the same reset, force outputs mem_we, mem_addr, mem_wdata, grabando, lleno and largo to 0.
REQ-030 SHALL apply reset mid-operation, including during WRITE, so that mem_we=0 from the next cycle.
REQ-031 SHALL leave a reset write unretried.
REQ-032 SHALL NOT start a take after reset release while grabar is held high; a new rising edge is needed.

Configuration
REQ-033 SHALL, with macro NOTE_RECORDER_WRAP_EN defined, wrap the pointer from 2**ADDR_W-1 to 0, return to REC and never enter FULL (circular take, lleno stays 0, largo saturates at 2**ADDR_W).
REQ-034 SHALL, without NOTE_RECORDER_WRAP_EN, stop at full per REQ-023.

Verification
REQ-035 SHALL cover: grabar rise, octave 3, note 5, one tick -> one cycle later mem_we=1, mem_addr=0, mem_wdata=31, then largo=1.
REQ-036 SHALL cover: ticks with (5,13), (1,1), (6,2), (2,0) -> mem_wdata 65, 1, 0, 0 at addresses 0..3; largo=4.
REQ-037 SHALL cover: ADDR_W=3, no macro, 9 ticks -> writes at addresses 0..7, lleno=1, largo=8, and no 9th write.
REQ-038 SHALL cover: ADDR_W=3, NOTE_RECORDER_WRAP_EN defined, 10 ticks -> addresses 0..7, 0, 1; lleno=0, largo=8.
REQ-039 SHALL cover: grabar falling in the same cycle as a tick -> no write and IDLE; a new grabar rise -> next write at address 0, largo restarts at 0.
REQ-040 SHALL cover: rst asserted in the WRITE cycle -> next cycle mem_we=0, all outputs 0, state IDLE.
